// File: rtl/ram_bus_arbiter.sv
// Shares one synchronous data RAM between the CPU datapath and an external loader/debug port.
// Latency: req seen in IDLE -> ACC next cycle -> WAIT -> done+rdata on the third cycle; one access per 3 cycles.
// Backpressure: level req held until done; optional EXT starvation guard under RAM_ARB_STARVE_GUARD_EN.
module ram_bus_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] ext_rdata,

    output logic          ram_ena,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

    state_t state;
    owner_t owner;
    logic   we;

    logic cpu_vld;
    logic ext_vld;
    logic ext_force;
    logic ext_win;
    logic cpu_win;
    logic win_we;

    if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_max_wait_check
        $error("ram_bus_arbiter: MAX_WAIT must be in 1..7");
    end

    // A port finishing this cycle sits out one arbitration so the other port gets a turn.
    assign cpu_vld = cpu_req & ~cpu_done;
    assign ext_vld = ext_req & ~ext_done;
    assign ext_win = ext_vld & (~cpu_vld | ext_force);
    assign cpu_win = cpu_vld & ~ext_win;
    assign win_we  = ext_win ? ext_we : cpu_we;

`ifdef RAM_ARB_STARVE_GUARD_EN
    logic [2:0] ext_wait;

    assign ext_force = (ext_wait == 3'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_wait <= '0;
        end else if (state == IDLE) begin
            if (ext_win) begin
                ext_wait <= '0;
            end else if (cpu_win && ext_vld && ext_wait != 3'd7) begin
                ext_wait <= ext_wait + 3'd1;
            end
        end
    end
`else
    assign ext_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            we        <= 1'b0;
            cpu_gnt   <= 1'b0;
            ext_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            ext_done  <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            ram_ena   <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            ext_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_win || ext_win) begin
                        state     <= ACC;
                        owner     <= ext_win ? OWN_EXT : OWN_CPU;
                        we        <= win_we;
                        ram_addr  <= ext_win ? ext_addr : cpu_addr;
                        ram_wdata <= ext_win ? ext_wdata : cpu_wdata;
                        ram_ena   <= 1'b1;
                        ram_read  <= ~win_we;
                        ram_write <= win_we;
                        cpu_gnt   <= cpu_win;
                        ext_gnt   <= ext_win;
                    end
                end
                ACC: begin
                    state     <= WAIT;
                    ram_ena   <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                end
                WAIT: begin
                    // RAM data from the ACC-cycle read strobe is valid now.
                    state   <= IDLE;
                    cpu_gnt <= 1'b0;
                    ext_gnt <= 1'b0;
                    if (owner == OWN_EXT) begin
                        ext_done <= 1'b1;
                        if (!we) ext_rdata <= ram_rdata;
                    end else begin
                        cpu_done <= 1'b1;
                        if (!we) cpu_rdata <= ram_rdata;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_gnt   <= 1'b0;
                    ext_gnt   <= 1'b0;
                    ram_ena   <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: cycle vector table, async-reset abort sequence, and random two-port traffic vs a transaction-level model.
`timescale 1ns/1ps
module tb_ram_bus_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          cpu_gnt, cpu_done, ext_gnt, ext_done;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          ram_ena, ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    ram_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
        .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the read strobe.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_ena && ram_read) ram_rdata <= mem[ram_addr];
        if (ram_ena && ram_write) mem[ram_addr] = ram_wdata;
    end

    typedef struct packed {
        logic cpu_req; logic cpu_we; logic [7:0] cpu_addr; logic [7:0] cpu_wdata;
        logic ext_req; logic ext_we; logic [7:0] ext_addr; logic [7:0] ext_wdata;
    } in_t;

    typedef struct packed {
        logic cpu_gnt; logic ext_gnt; logic ram_ena; logic ram_read; logic ram_write;
        logic [7:0] ram_addr; logic [7:0] ram_wdata;
        logic cpu_done; logic ext_done;
        logic [7:0] cpu_rdata; logic [7:0] ext_rdata;
    } out_t;

    typedef struct packed { in_t i; out_t o; } vec_t;

    out_t dut_out;
    assign dut_out = {cpu_gnt, ext_gnt, ram_ena, ram_read, ram_write, ram_addr, ram_wdata,
                      cpu_done, ext_done, cpu_rdata, ext_rdata};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int idx, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    // Transaction-level model: each grant occupies the bus for three cycles, the
    // access takes effect at completion, and a port that just completed sits out one arbitration.
    logic [7:0] shadow [256];
    int         m_rem = 0;
    bit         m_own_ext = 0, m_we = 0, m_cpu_done = 0, m_ext_done = 0;
    bit         m_cv, m_ev, m_ext_wins;
    int         m_ext_wait = 0;
    logic [7:0] m_addr = 0, m_wdata = 0, m_cpu_rdata = 0, m_ext_rdata = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem = 0; m_own_ext = 0; m_we = 0; m_cpu_done = 0; m_ext_done = 0;
            m_addr = 0; m_wdata = 0; m_cpu_rdata = 0; m_ext_rdata = 0; m_ext_wait = 0;
        end else begin
            m_cv = cpu_req && !m_cpu_done;
            m_ev = ext_req && !m_ext_done;
            m_cpu_done = 0;
            m_ext_done = 0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_we) shadow[m_addr] = m_wdata;
                    else if (m_own_ext) m_ext_rdata = shadow[m_addr];
                    else m_cpu_rdata = shadow[m_addr];
                    if (m_own_ext) m_ext_done = 1; else m_cpu_done = 1;
                end
            end else if (m_cv || m_ev) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
                m_ext_wins = m_ev && (!m_cv || m_ext_wait == MAX_WAIT);
                if (m_ext_wins) m_ext_wait = 0;
                else if (m_ev && m_ext_wait < 7) m_ext_wait = m_ext_wait + 1;
`else
                m_ext_wins = m_ev && !m_cv;
`endif
                m_own_ext = m_ext_wins;
                m_we      = m_ext_wins ? ext_we : cpu_we;
                m_addr    = m_ext_wins ? ext_addr : cpu_addr;
                m_wdata   = m_ext_wins ? ext_wdata : cpu_wdata;
                m_rem     = 2;
            end
        end
    end

    function automatic out_t model_out();
        out_t o;
        o.cpu_gnt   = (m_rem > 0) && !m_own_ext;
        o.ext_gnt   = (m_rem > 0) && m_own_ext;
        o.ram_ena   = (m_rem == 2);
        o.ram_read  = (m_rem == 2) && !m_we;
        o.ram_write = (m_rem == 2) && m_we;
        o.ram_addr  = m_addr;
        o.ram_wdata = m_wdata;
        o.cpu_done  = m_cpu_done;
        o.ext_done  = m_ext_done;
        o.cpu_rdata = m_cpu_rdata;
        o.ext_rdata = m_ext_rdata;
        return o;
    endfunction

    bit chk_en = 0;
    int cyc = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            check("model", cyc, dut_out, model_out());
        end
    end

    function automatic in_t ci(bit cr, bit cw, logic [7:0] ca, logic [7:0] cd,
                               bit er, bit ew, logic [7:0] ea, logic [7:0] ed);
        return {cr, cw, ca, cd, er, ew, ea, ed};
    endfunction

    function automatic out_t co(bit cg, bit eg, bit en, bit rd, bit wr, logic [7:0] a, logic [7:0] wd,
                                bit cdn, bit edn, logic [7:0] crd, logic [7:0] erd);
        return {cg, eg, en, rd, wr, a, wd, cdn, edn, crd, erd};
    endfunction

    task automatic drive(input in_t v);
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        ext_req = v.ext_req; ext_we = v.ext_we; ext_addr = v.ext_addr; ext_wdata = v.ext_wdata;
    endtask

    vec_t tbl [$];
    bit   cpu_busy = 0, ext_busy = 0, done_seen;
    in_t  idle_in;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 1);
            shadow[i] = mem[i];
        end
        mem[8'h2A] = 8'h5C; shadow[8'h2A] = 8'h5C;
        mem[8'h03] = 8'h11; shadow[8'h03] = 8'h11;
        mem[8'h10] = 8'h77; shadow[8'h10] = 8'h77;
        idle_in = ci(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Inputs held during cycle k, outputs expected in cycle k+1.
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(1,0,1,1,0,8'h2A,8'h00,0,0,8'h00,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(1,0,0,0,0,8'h2A,8'h00,0,0,8'h00,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(0,0,0,0,0,8'h2A,8'h00,1,0,8'h5C,8'h00)});
        tbl.push_back({idle_in,                              co(0,0,0,0,0,8'h2A,8'h00,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(0,0,8'h00,8'h00, 1,1,8'h03,8'hA5), co(0,1,1,0,1,8'h03,8'hA5,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(0,0,8'h00,8'h00, 1,1,8'h03,8'hA5), co(0,1,0,0,0,8'h03,8'hA5,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(0,0,8'h00,8'h00, 1,1,8'h03,8'hA5), co(0,0,0,0,0,8'h03,8'hA5,0,1,8'h5C,8'h00)});
        tbl.push_back({idle_in,                              co(0,0,0,0,0,8'h03,8'hA5,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(1,0,8'h03,8'h00, 0,0,8'h00,8'h00), co(1,0,1,1,0,8'h03,8'h00,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(1,0,8'h03,8'h00, 0,0,8'h00,8'h00), co(1,0,0,0,0,8'h03,8'h00,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(0,0,8'h03,8'h00, 0,0,8'h00,8'h00), co(0,0,0,0,0,8'h03,8'h00,1,0,8'hA5,8'h00)});
        tbl.push_back({idle_in,                              co(0,0,0,0,0,8'h03,8'h00,0,0,8'hA5,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(1,0,1,1,0,8'h2A,8'h00,0,0,8'hA5,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(1,0,0,0,0,8'h2A,8'h00,0,0,8'hA5,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(0,0,0,0,0,8'h2A,8'h00,1,0,8'h5C,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(0,1,1,1,0,8'h03,8'h00,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(0,1,0,0,0,8'h03,8'h00,0,0,8'h5C,8'h00)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 1,0,8'h03,8'h00), co(0,0,0,0,0,8'h03,8'h00,0,1,8'h5C,8'hA5)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(1,0,1,1,0,8'h2A,8'h00,0,0,8'h5C,8'hA5)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(1,0,0,0,0,8'h2A,8'h00,0,0,8'h5C,8'hA5)});
        tbl.push_back({ci(1,0,8'h2A,8'h00, 0,0,8'h00,8'h00), co(0,0,0,0,0,8'h2A,8'h00,1,0,8'h5C,8'hA5)});
        tbl.push_back({idle_in,                              co(0,0,0,0,0,8'h2A,8'h00,0,0,8'h5C,8'hA5)});

        repeat (2) @(negedge clk);
        check("reset_state", 0, dut_out, '0);
        rst    = 1'b1;
        chk_en = 1;

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            @(negedge clk);
            check("vec", k, dut_out, tbl[k].o);
        end

        // Reset lands in the ACC cycle of a CPU write: the write must never reach the RAM.
        drive(ci(1, 1, 8'h10, 8'hEE, 0, 0, 8'h00, 8'h00));
        @(negedge clk);
        check_bit("rst_pre_write_strobe", ram_write, 1'b1);
        #1 rst = 1'b0;
        #1 check("rst_outputs", 0, dut_out, '0);
        @(negedge clk);
        drive(idle_in);
        rst = 1'b1;
        done_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_done) done_seen = 1;
        end
        check_bit("rst_no_done", done_seen, 1'b0);
        n_tests++;
        if (mem[8'h10] !== 8'h77) begin
            n_fail++;
            $display("FAIL rst_ram_unchanged got=%h want=77", mem[8'h10]);
        end

        // Random traffic: each port keeps one outstanding request and may withdraw once granted.
        for (int c = 0; c < 1500; c++) begin
            if (cpu_done) cpu_busy = 0;
            if (ext_done) ext_busy = 0;
            if (!cpu_busy) begin
                if ($urandom_range(0, 2) != 0) begin
                    cpu_req = 1; cpu_busy = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
                end else begin
                    cpu_req = 0;
                end
            end else if (cpu_gnt && $urandom_range(0, 7) == 0) begin
                cpu_req = 0;
            end
            if (!ext_busy) begin
                if ($urandom_range(0, 2) != 0) begin
                    ext_req = 1; ext_busy = 1; ext_we = 1'($urandom_range(0, 1));
                    ext_addr = 8'($urandom_range(0, 15)); ext_wdata = 8'($urandom);
                end else begin
                    ext_req = 0;
                end
            end else if (ext_gnt && $urandom_range(0, 7) == 0) begin
                ext_req = 0;
            end
            @(negedge clk);
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
